param_int_divider: RTL and testbench



---
 rtl/param_int_div_pkg.sv | 20 ++
 rtl/param_int_div_dp.sv | 116 +++++++++++
 rtl/param_int_divider.sv | 119 +++++++++++
 tb/tb_param_int_divider.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_int_div_pkg.sv
// Shared definitions for the parametrised restoring integer divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package param_int_div_pkg;

    // Controller state encoding. S_FIX is only entered when SIGNED_DIV_EN is defined.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_e;

    // Width of the iteration counter: it must hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/param_int_div_dp.sv
// Divider datapath: X/Y/R/Q registers, WIDTH+1 compare/subtract, sign fix-up, result registers.
// Latency: one quotient bit per step_i strobe; results update on the commit_i (or divide-by-zero load) edge.
// Backpressure: none, purely strobe-driven by the controller.
// Macro SIGNED_DIV_EN adds signed_mode_i / fix_i and the sign-correction path.
module param_int_div_dp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             commit_i,
`ifdef SIGNED_DIV_EN
    input  logic             fix_i,
    input  logic             signed_mode_i,
`endif
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             dbz_o
);

    logic [WIDTH-1:0] x_q, y_q, q_q;
    // R < Y holds after every step, so R fits in WIDTH bits; only the trial value T needs WIDTH+1.
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] quo_q, rem_q;
    logic             dbz_q;

    logic [WIDTH:0]   t_val;
    logic             ge;
    logic [WIDTH-1:0] r_step, q_step;
    logic [WIDTH-1:0] x_ld, y_ld;
    logic [WIDTH-1:0] q_res, r_res;

`ifdef SIGNED_DIV_EN
    logic neg_a, neg_b;
    logic neg_q_q, neg_r_q;
`endif

    assign div_zero_o = (divisor_i == '0);

    // One restoring step: shift the next dividend bit into the partial remainder and try Y.
    always_comb begin
        t_val  = {r_q, x_q[WIDTH-1]};
        ge     = (t_val >= {1'b0, y_q});
        r_step = ge ? WIDTH'(t_val - {1'b0, y_q}) : t_val[WIDTH-1:0];
        q_step = {q_q[WIDTH-2:0], ge};
    end

`ifdef SIGNED_DIV_EN
    // Signed operands are divided as magnitudes; the signs are reapplied in FIX.
    always_comb begin
        neg_a = signed_mode_i & dividend_i[WIDTH-1];
        neg_b = signed_mode_i & divisor_i[WIDTH-1];
        x_ld  = neg_a ? ('0 - dividend_i) : dividend_i;
        y_ld  = neg_b ? ('0 - divisor_i)  : divisor_i;
        q_res = fix_i ? (neg_q_q ? ('0 - q_q) : q_q) : q_step;
        r_res = fix_i ? (neg_r_q ? ('0 - r_q) : r_q) : r_step;
    end
`else
    always_comb begin
        x_ld  = dividend_i;
        y_ld  = divisor_i;
        q_res = q_step;
        r_res = r_step;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else if (load_i) begin
            x_q     <= x_ld;
            y_q     <= y_ld;
            r_q     <= '0;
            q_q     <= '0;
            dbz_q   <= div_zero_o;
`ifdef SIGNED_DIV_EN
            neg_q_q <= neg_a ^ neg_b;
            neg_r_q <= neg_a;
`endif
            // Divide-by-zero skips the iterations, so its results are published here.
            if (div_zero_o) begin
                quo_q <= '1;
                rem_q <= dividend_i;
            end
        end else begin
            if (step_i) begin
                x_q <= {x_q[WIDTH-2:0], 1'b0};
                r_q <= r_step;
                q_q <= q_step;
            end
            if (commit_i) begin
                quo_q <= q_res;
                rem_q <= r_res;
            end
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign dbz_o       = dbz_q;

endmodule

// File: rtl/param_int_divider.sv
// Radix-2 restoring unsigned divider (optional signed mode via macro SIGNED_DIV_EN), FSM + counter top.
// Latency: go applied at edge 0 -> done after edge WIDTH+2 (WIDTH+3 with SIGNED_DIV_EN); divide-by-zero after edge 2.
// Backpressure: go is accepted only in IDLE; go while busy is dropped, not queued.
// Ports: clk/rst_n (sync, active-low); go, dividend, divisor[, signed_mode] in;
//        quotient, remainder, dbz (held until next LOAD), busy, done (one-cycle pulse) out.
module param_int_divider
    import param_int_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic             signed_mode,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_s, step_s, commit_s;
    logic             div_zero;
    logic             last_iter;
`ifdef SIGNED_DIV_EN
    logic             fix_s;
`endif

    assign last_iter = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_s   = 1'b0;
        step_s   = 1'b0;
        commit_s = 1'b0;
`ifdef SIGNED_DIV_EN
        fix_s    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_LOAD;
            end
            S_LOAD: begin
                load_s  = 1'b1;
                cnt_d   = CNT_W'(WIDTH);
                state_d = div_zero ? S_DONE : S_ITER;
            end
            S_ITER: begin
                step_s = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (last_iter) begin
`ifdef SIGNED_DIV_EN
                    state_d = S_FIX;
`else
                    // Results are captured from the final step so they are valid with done.
                    commit_s = 1'b1;
                    state_d  = S_DONE;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            S_FIX: begin
                fix_s    = 1'b1;
                commit_s = 1'b1;
                state_d  = S_DONE;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    param_int_div_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (load_s),
        .step_i        (step_s),
        .commit_i      (commit_s),
`ifdef SIGNED_DIV_EN
        .fix_i         (fix_s),
        .signed_mode_i (signed_mode),
`endif
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .div_zero_o    (div_zero),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .dbz_o         (dbz)
    );

endmodule

// File: tb/tb_param_int_divider.sv
// Directed bench for param_int_divider (WIDTH=8).
// Latency: checks done timing against edge counts from the go edge.
// Backpressure: exercises go held high across an operation.
module tb_param_int_divider;

    localparam int W = 8;
`ifdef SIGNED_DIV_EN
    localparam int LAT = W + 3;
`else
    localparam int LAT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         go = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
`ifdef SIGNED_DIV_EN
    logic         signed_mode = 1'b0;
`endif
    logic [W-1:0] quotient, remainder;
    logic         busy, done, dbz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_int_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SIGNED_DIV_EN
        .signed_mode (signed_mode),
`endif
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .dbz         (dbz)
    );

    // Applies go for one cycle (the posedge before is edge 0) and watches edges 1..40.
    // Returns the edge after which done was seen (-1 on timeout), captured results,
    // number of cycles busy was not high, and whether the cycle after done was clean.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int busy_bad, output logic tail_ok);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        go       = 1'b1;
        lat = -1; q = '0; r = '0; z = 1'b0; busy_bad = 0; tail_ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) go = 1'b0;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                lat = k; q = quotient; r = remainder; z = dbz;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            @(negedge clk);
            tail_ok = (done === 1'b0) && (busy === 1'b0) && (quotient === q) &&
                      (remainder === r) && (dbz === z);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({quotient, remainder, busy, done, dbz} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: q=%h r=%h busy=%b done=%b dbz=%b, required all zero",
                     quotient, remainder, busy, done, dbz);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bb; logic [W-1:0] q, r; logic z, tl;
        run_op(8'd100, 8'd7, lat, q, r, z, bb, tl);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d, required %0d", lat, LAT); end
        checks++; if (q !== 8'd14) begin errors++; $display("FAIL basic_quotient: got %0d, required 14", q); end
        checks++; if (r !== 8'd2) begin errors++; $display("FAIL basic_remainder: got %0d, required 2", r); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b, required 0", z); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL basic_busy: %0d cycles low, required 0", bb); end
        checks++; if (tl !== 1'b1) begin errors++; $display("FAIL basic_after_done: got %b, required 1", tl); end
    endtask

    task automatic test_div_by_zero();
        int lat, bb; logic [W-1:0] q, r; logic z, tl;
        run_op(8'd5, 8'd0, lat, q, r, z, bb, tl);
        checks++; if (lat !== 2) begin errors++; $display("FAIL dbz_latency: got %0d, required 2", lat); end
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL dbz_quotient: got %h, required ff", q); end
        checks++; if (r !== 8'd5) begin errors++; $display("FAIL dbz_remainder: got %0d, required 5", r); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b, required 1", z); end
        checks++; if (tl !== 1'b1) begin errors++; $display("FAIL dbz_held: got %b, required 1", tl); end
        run_op(8'd9, 8'd3, lat, q, r, z, bb, tl);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL after_dbz_latency: got %0d, required %0d", lat, LAT); end
        checks++; if (q !== 8'd3 || r !== 8'd0) begin errors++; $display("FAIL after_dbz_result: got %0d r %0d, required 3 r 0", q, r); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL after_dbz_flag: got %b, required 0", z); end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] va [3] = '{8'd255, 8'd3,   8'd255};
        logic [W-1:0] vb [3] = '{8'd1,   8'd200, 8'd255};
        logic [W-1:0] eq [3] = '{8'd255, 8'd0,   8'd1};
        logic [W-1:0] er [3] = '{8'd0,   8'd3,   8'd0};
        int lat, bb; logic [W-1:0] q, r; logic z, tl;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], lat, q, r, z, bb, tl);
            checks++;
            if (lat !== LAT || q !== eq[i] || r !== er[i] || z !== 1'b0) begin
                errors++;
                $display("FAIL boundary_%0d: %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d, required q=%0d r=%0d dbz=0 lat=%0d",
                         i, va[i], vb[i], q, r, z, lat, eq[i], er[i], LAT);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bb, ndone; logic [W-1:0] q, r; logic z, tl;
        @(negedge clk);
        dividend = 8'd200; divisor = 8'd9; go = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) go = 1'b0;
            if (k == 4) rst_n = 1'b0;
        end
        checks++;
        if ({quotient, remainder, busy, done, dbz} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: q=%h r=%h busy=%b done=%b dbz=%b, required all zero",
                     quotient, remainder, busy, done, dbz);
        end
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL midrun_no_done: %0d active cycles, required 0", ndone); end
        run_op(8'd200, 8'd9, lat, q, r, z, bb, tl);
        checks++;
        if (lat !== LAT || q !== 8'd22 || r !== 8'd2) begin
            errors++;
            $display("FAIL midrun_restart: got q=%0d r=%0d lat=%0d, required q=22 r=2 lat=%0d", q, r, lat, LAT);
        end
    endtask

    task automatic test_go_held();
        int first, second, ndone;
        logic [W-1:0] q1, r1, q2, r2;
        first = -1; second = -1; ndone = 0; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; go = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 3) begin dividend = 8'd50; divisor = 8'd5; end
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) begin first = k; q1 = quotient; r1 = remainder; end
                else if (second < 0) begin second = k; q2 = quotient; r2 = remainder; go = 1'b0; end
            end
        end
        go = 1'b0;
        checks++;
        if (first !== LAT || q1 !== 8'd14 || r1 !== 8'd2) begin
            errors++;
            $display("FAIL goheld_first: got q=%0d r=%0d at edge %0d, required 14 r 2 at edge %0d", q1, r1, first, LAT);
        end
        checks++;
        if (second !== 2 * LAT + 1 || q2 !== 8'd10 || r2 !== 8'd0) begin
            errors++;
            $display("FAIL goheld_second: got q=%0d r=%0d at edge %0d, required 10 r 0 at edge %0d",
                     q2, r2, second, 2 * LAT + 1);
        end
        checks++; if (ndone !== 2) begin errors++; $display("FAIL goheld_count: got %0d done pulses, required 2", ndone); end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        logic [W-1:0] va [3] = '{8'hF9, 8'h07, 8'h80};
        logic [W-1:0] vb [3] = '{8'h02, 8'hFE, 8'hFF};
        logic [W-1:0] eq [3] = '{8'hFD, 8'hFD, 8'h80};
        logic [W-1:0] er [3] = '{8'hFF, 8'h01, 8'h00};
        int lat, bb; logic [W-1:0] q, r; logic z, tl;
        signed_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], lat, q, r, z, bb, tl);
            checks++;
            if (lat !== LAT || q !== eq[i] || r !== er[i] || z !== 1'b0) begin
                errors++;
                $display("FAIL signed_%0d: %h/%h got q=%h r=%h dbz=%b lat=%0d, required q=%h r=%h dbz=0 lat=%0d",
                         i, va[i], vb[i], q, r, z, lat, eq[i], er[i], LAT);
            end
        end
        signed_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_boundaries();
        test_reset_mid_run();
        test_go_held();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
